input_entry: RTL and testbench

Decimal input entry block for the MIPS processor's input instruction: the input-side counterpart of the two-digit 7-segment display path. While the processor requests input, it reads a decimal digit from four slide switches on each debounced press of a digit key and accumulates the digits into a 32-bit binary value. The enter key completes the entry, and the value is handed to the processor over a valid/flag handshake. The accumulated value is also exported continuously so the display path can echo the digits as they are typed.

---
 rtl/input_entry.sv | 165 ++++++++++++++++
 tb/tb_input_entry.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_entry.sv
// Decimal keypad entry for the processor's input instruction: debounced digit/enter keys
// accumulate a BCD-typed value into a 32-bit binary word handed over with a valid flag.

module input_entry_key #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clock_i,
    input  logic rst_ni,
    input  logic key_ni,
    output logic press_o
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic [1:0]       settle_q, settle_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             acc_q, acc_d;
    logic             armed_q, armed_d;
    logic             press_q, press_d;

    always_comb begin
        sync_d   = {sync_q[0], key_ni};
        settle_d = {settle_q[0], 1'b1};
        acc_d    = acc_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        if (sync_q[1] != acc_q) begin
            if (cnt_q == CNT_LAST) begin
                acc_d   = sync_q[1];
                press_d = armed_q & acc_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // A key held through reset must be seen released before it can press.
        armed_d = armed_q | (settle_q[1] & acc_q & sync_q[1]);
    end

    always_ff @(posedge clock_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= 2'b11;
            settle_q <= 2'b00;
            cnt_q    <= '0;
            acc_q    <= 1'b1;
            armed_q  <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            settle_q <= settle_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            armed_q  <= armed_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;
endmodule

module input_entry #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int MAX_DIGITS      = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  SW,
    input  logic        KEY_digit,
    input  logic        KEY_enter,
    input  logic        input_flag,
    output logic [31:0] valor,
    output logic        valid,
    output logic        waiting
);
    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

    state_t      state_q;
    logic [31:0] valor_q;
    logic [3:0]  count_q;
    logic        valid_q, waiting_q;
    logic        digit_press, enter_press;
    logic        digit_ok;
    logic [31:0] valor_d;

    input_entry_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_digit (
        .clock_i (clock),
        .rst_ni  (reset),
        .key_ni  (KEY_digit),
        .press_o (digit_press)
    );

    input_entry_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_enter (
        .clock_i (clock),
        .rst_ni  (reset),
        .key_ni  (KEY_enter),
        .press_o (enter_press)
    );

    assign digit_ok = digit_press && (SW <= 4'd9) && (count_q < MAX_CNT);
    assign valor_d  = (valor_q << 3) + (valor_q << 1) + {28'd0, SW};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            valor_q   <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            waiting_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    valor_q <= '0;
                    count_q <= '0;
                    valid_q <= 1'b0;
                    if (input_flag) begin
                        state_q   <= COLLECT;
                        waiting_q <= 1'b1;
                    end else begin
                        waiting_q <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (!input_flag) begin
                        state_q   <= IDLE;
                        valor_q   <= '0;
                        count_q   <= '0;
                        waiting_q <= 1'b0;
                    end else begin
                        // A digit landing with enter is folded in before completing.
                        if (digit_ok) begin
                            valor_q <= valor_d;
                            count_q <= count_q + 4'd1;
                        end
                        if (enter_press) begin
                            state_q   <= DONE;
                            waiting_q <= 1'b0;
                            valid_q   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!input_flag) begin
                        state_q <= IDLE;
                        valor_q <= '0;
                        count_q <= '0;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    valor_q   <= '0;
                    count_q   <= '0;
                    valid_q   <= 1'b0;
                    waiting_q <= 1'b0;
                end
            endcase
        end
    end

    assign valor   = valor_q;
    assign valid   = valid_q;
    assign waiting = waiting_q;
endmodule

// File: tb/tb_input_entry.sv
// Bench for input_entry: vector table, cycle-exact hand sequences and a randomized
// run against a transaction-level model of the keypad entry.

module tb_input_entry;
    localparam int DEB  = 4;
    localparam int MAXD = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  SW = 4'd0;
    logic        KEY_digit = 1'b1;
    logic        KEY_enter = 1'b1;
    logic        input_flag = 1'b0;
    logic [31:0] valor;
    logic        valid;
    logic        waiting;

    input_entry #(.DEBOUNCE_CYCLES(DEB), .MAX_DIGITS(MAXD)) dut (
        .clock      (clock),
        .reset      (reset),
        .SW         (SW),
        .KEY_digit  (KEY_digit),
        .KEY_enter  (KEY_enter),
        .input_flag (input_flag),
        .valor      (valor),
        .valid      (valid),
        .waiting    (waiting)
    );

    always #5 clock = ~clock;

    typedef enum int {OP_FLAG1, OP_FLAG0, OP_DIGIT, OP_ENTER, OP_BOTH} op_t;
    typedef struct {
        op_t         op;
        logic [3:0]  sw;
        logic [31:0] valor;
        logic        valid;
        logic        waiting;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    int   valid_rises = 0;
    logic valid_prev  = 1'b0;
    always @(negedge clock) begin
        if (valid && !valid_prev) valid_rises <= valid_rises + 1;
        valid_prev <= valid;
    end

    // Transaction-level model: 0 idle, 1 collecting, 2 done.
    int          m_state = 0;
    logic [31:0] m_val   = 0;
    int          m_cnt   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_digit(input logic [3:0] sw);
        if (m_state == 1 && sw <= 9 && m_cnt < MAXD) begin
            m_val = m_val * 10 + 32'(sw);
            m_cnt++;
        end
    endtask

    task automatic model_apply(input op_t op, input logic [3:0] sw);
        case (op)
            OP_FLAG1: if (m_state == 0) m_state = 1;
            OP_FLAG0: begin m_state = 0; m_val = 0; m_cnt = 0; end
            OP_DIGIT: model_digit(sw);
            OP_ENTER: if (m_state == 1) m_state = 2;
            OP_BOTH:  begin model_digit(sw); if (m_state == 1) m_state = 2; end
            default:  ;
        endcase
    endtask

    task automatic do_op(input op_t op, input logic [3:0] sw);
        @(posedge clock); #1;
        SW = sw;
        case (op)
            OP_FLAG1: begin input_flag = 1'b1; repeat (3) @(posedge clock); end
            OP_FLAG0: begin input_flag = 1'b0; repeat (3) @(posedge clock); end
            default: begin
                if (op != OP_ENTER) KEY_digit = 1'b0;
                if (op != OP_DIGIT) KEY_enter = 1'b0;
                repeat (8) @(posedge clock);
                #1;
                KEY_digit = 1'b1;
                KEY_enter = 1'b1;
                repeat (10) @(posedge clock);
            end
        endcase
        @(negedge clock);
    endtask

    vec_t vecs[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          rises0;
        logic        changed;
        logic [31:0] prev;
        op_t         rop;
        logic [3:0]  rsw;

        // Basic entry, then digit limit / invalid digits, simultaneous keys, idle and abort.
        vecs.push_back('{OP_FLAG1, 4'd0,  32'd0,  1'b0, 1'b1});
        vecs.push_back('{OP_DIGIT, 4'd4,  32'd4,  1'b0, 1'b1});
        vecs.push_back('{OP_DIGIT, 4'd2,  32'd42, 1'b0, 1'b1});
        vecs.push_back('{OP_ENTER, 4'd0,  32'd42, 1'b1, 1'b0});
        vecs.push_back('{OP_FLAG0, 4'd0,  32'd0,  1'b0, 1'b0});
        vecs.push_back('{OP_FLAG1, 4'd0,  32'd0,  1'b0, 1'b1});
        vecs.push_back('{OP_DIGIT, 4'd7,  32'd7,  1'b0, 1'b1});
        vecs.push_back('{OP_DIGIT, 4'd12, 32'd7,  1'b0, 1'b1});
        vecs.push_back('{OP_DIGIT, 4'd3,  32'd73, 1'b0, 1'b1});
        vecs.push_back('{OP_DIGIT, 4'd9,  32'd73, 1'b0, 1'b1});
        vecs.push_back('{OP_ENTER, 4'd0,  32'd73, 1'b1, 1'b0});
        vecs.push_back('{OP_DIGIT, 4'd1,  32'd73, 1'b1, 1'b0});
        vecs.push_back('{OP_FLAG0, 4'd0,  32'd0,  1'b0, 1'b0});
        vecs.push_back('{OP_FLAG1, 4'd0,  32'd0,  1'b0, 1'b1});
        vecs.push_back('{OP_BOTH,  4'd5,  32'd5,  1'b1, 1'b0});
        vecs.push_back('{OP_FLAG0, 4'd0,  32'd0,  1'b0, 1'b0});
        vecs.push_back('{OP_FLAG1, 4'd0,  32'd0,  1'b0, 1'b1});
        vecs.push_back('{OP_ENTER, 4'd0,  32'd0,  1'b1, 1'b0});
        vecs.push_back('{OP_FLAG0, 4'd0,  32'd0,  1'b0, 1'b0});
        vecs.push_back('{OP_DIGIT, 4'd3,  32'd0,  1'b0, 1'b0});
        vecs.push_back('{OP_ENTER, 4'd0,  32'd0,  1'b0, 1'b0});

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_valor", valor, 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_waiting", 32'(waiting), 32'd0);
        reset = 1'b1;
        repeat (4) @(posedge clock);

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].sw);
            check($sformatf("vec%0d_valor", i), valor, vecs[i].valor);
            check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d_waiting", i), 32'(waiting), 32'(vecs[i].waiting));
        end

        // Handshake edges: waiting one cycle after flag rises, valid one cycle after it falls.
        @(posedge clock); #1 input_flag = 1'b1;
        @(negedge clock); check("waiting_before_edge", 32'(waiting), 32'd0);
        @(negedge clock); check("waiting_after_edge", 32'(waiting), 32'd1);
        do_op(OP_DIGIT, 4'd4);
        do_op(OP_DIGIT, 4'd2);
        do_op(OP_ENTER, 4'd0);
        check("hs_valor", valor, 32'd42);
        @(posedge clock); #1 input_flag = 1'b0;
        @(negedge clock); check("valid_before_edge", 32'(valid), 32'd1);
        @(negedge clock); check("valid_after_edge", 32'(valid), 32'd0);
        check("valor_after_drop", valor, 32'd0);

        // Abort mid-entry: valid must never rise.
        rises0 = valid_rises;
        do_op(OP_FLAG1, 4'd0);
        do_op(OP_DIGIT, 4'd8);
        check("abort_digit", valor, 32'd8);
        do_op(OP_FLAG0, 4'd0);
        check("abort_valor", valor, 32'd0);
        check("abort_waiting", 32'(waiting), 32'd0);
        check("abort_no_valid", 32'(valid_rises - rises0), 32'd0);

        // Debounce: short glitches ignored, held press gives one pulse with fixed latency.
        do_op(OP_FLAG1, 4'd1);
        @(posedge clock); #1 KEY_digit = 1'b0;
        repeat (3) @(posedge clock); #1 KEY_digit = 1'b1;
        @(posedge clock); #1 KEY_digit = 1'b0;
        repeat (3) @(posedge clock); #1 KEY_digit = 1'b1;
        repeat (12) @(posedge clock);
        @(negedge clock);
        check("bounce_no_press", valor, 32'd0);
        @(posedge clock); #1 KEY_digit = 1'b0;
        prev = valor; n = 0; changed = 1'b0;
        for (int k = 0; k < 20 && !changed; k++) begin
            @(posedge clock); n++;
            @(negedge clock);
            if (valor != prev) changed = 1'b1;
        end
        check("press_latency_edges", 32'(n), 32'd7);
        repeat (10 - n) @(posedge clock);
        #1 KEY_digit = 1'b1;
        repeat (15) @(posedge clock);
        @(negedge clock);
        check("hold_single_press", valor, 32'd1);
        do_op(OP_FLAG0, 4'd0);

        // Reset during collection with the digit key held.
        do_op(OP_FLAG1, 4'd0);
        do_op(OP_DIGIT, 4'd6);
        check("pre_reset_valor", valor, 32'd6);
        @(posedge clock); #1 SW = 4'd7; KEY_digit = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("async_reset_valor", valor, 32'd0);
        check("async_reset_valid", 32'(valid), 32'd0);
        check("async_reset_waiting", 32'(waiting), 32'd0);
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        repeat (20) @(posedge clock);
        @(negedge clock);
        check("held_key_no_press", valor, 32'd0);
        check("held_key_waiting", 32'(waiting), 32'd1);
        @(posedge clock); #1 KEY_digit = 1'b1;
        repeat (12) @(posedge clock);
        do_op(OP_DIGIT, 4'd7);
        check("repress_after_reset", valor, 32'd7);

        // Randomized operations against the model.
        do_op(OP_FLAG0, 4'd0);
        m_state = 0; m_val = 0; m_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            n   = int'($urandom_range(0, 9));
            rsw = 4'($urandom_range(0, 15));
            case (n)
                0, 1:    rop = OP_FLAG1;
                2:       rop = OP_FLAG0;
                7:       rop = OP_ENTER;
                8:       rop = OP_BOTH;
                default: rop = OP_DIGIT;
            endcase
            do_op(rop, rsw);
            model_apply(rop, rsw);
            check($sformatf("rnd%0d_valor", k), valor, m_val);
            check($sformatf("rnd%0d_valid", k), 32'(valid), 32'(m_state == 2));
            check($sformatf("rnd%0d_waiting", k), 32'(waiting), 32'(m_state == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
